// File: rtl/calc_sequencer.sv
// Operand/opcode sequencer for the 8-bit calculator ALU: collects A, B, opcode, holds the ALU
// inputs for SETTLE_CYCLES and captures the result. Define CALC_SEQ_CHAIN_EN for chained totals.
module calc_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic [2:0] op_in,
  input  logic       op_valid,
  input  logic       clear,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_result,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic [1:0] phase,
  output logic       err
);

  // Handshake: data_valid/op_valid are single-cycle pulses with no ready; a pulse is consumed
  // only in the state that expects it (GET_A/GET_B for data, GET_OP for op) and is otherwise dropped.
  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    EXEC   = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  assign phase = state;
  assign busy  = (state == EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= GET_A;
      cnt          <= 4'd0;
      alu_in1      <= 8'h00;
      alu_in2      <= 8'h00;
      alu_opcode   <= 3'b000;
      result       <= 8'h00;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clear) begin
        // Operands, opcode, result and err are deliberately kept across an abort.
        state <= GET_A;
        cnt   <= 4'd0;
      end else begin
        case (state)
          GET_A: begin
            if (data_valid) begin
              alu_in1 <= data_in;
              state   <= GET_B;
            end
          end
          GET_B: begin
            if (data_valid) begin
              alu_in2 <= data_in;
              state   <= GET_OP;
            end
          end
          GET_OP: begin
            if (op_valid) begin
              alu_opcode <= op_in;
              err        <= 1'b0;
              cnt        <= 4'd0;
              state      <= EXEC;
            end
          end
          EXEC: begin
            if (cnt == LAST_CNT) begin
              result       <= alu_result;
              result_valid <= 1'b1;
              err          <= (alu_opcode >= 3'b101);
`ifdef CALC_SEQ_CHAIN_EN
              alu_in1      <= alu_result;
              state        <= GET_B;
`else
              state        <= GET_A;
`endif
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: state <= GET_A;
        endcase
      end
    end
  end

endmodule
